// File: rtl/alu_pkg.sv
// Shared constants, opcodes and state encoding
// for the ALU execute/writeback sequencer.
package alu_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_SEL_W  = 8;
  localparam int ALU_FLAG_W = 7;
  localparam int ALU_ADDR_W = 3;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_MUL  = 8'h03;
  localparam logic [7:0] OP_DIV  = 8'h04;
  localparam logic [7:0] OP_INC  = 8'h05;
  localparam logic [7:0] OP_DEC  = 8'h06;
  localparam logic [7:0] OP_MOD  = 8'h07;
  localparam logic [7:0] OP_SHL  = 8'h08;
  localparam logic [7:0] OP_SHR  = 8'h09;
  localparam logic [7:0] OP_AND  = 8'h0A;
  localparam logic [7:0] OP_NAND = 8'h0B;
  localparam logic [7:0] OP_NOR  = 8'h0D;
  localparam logic [7:0] OP_OR   = 8'h0F;
  localparam logic [7:0] OP_XNOR = 8'h10;
  localparam logic [7:0] OP_XOR  = 8'h11;
  localparam logic [7:0] OP_ROL  = 8'h12;
  localparam logic [7:0] OP_ROR  = 8'h13;
  localparam logic [7:0] OP_LDI  = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  function automatic logic is_alu_op(input logic [7:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV,
                      OP_INC, OP_DEC, OP_MOD, OP_SHL,
                      OP_SHR, OP_AND, OP_NAND, OP_NOR,
                      OP_OR, OP_XNOR, OP_XOR, OP_ROL,
                      OP_ROR};
  endfunction

endpackage

// File: rtl/regfile_8x8.sv
// Register file: two combinational read ports, one debug
// read port, one synchronous write port, async clear.
module regfile_8x8
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int ADDR_W = ALU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rs1_data = mem_q[rs1_addr];
  assign rs2_data = mem_q[rs2_addr];
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_exec_sequencer.sv
// Execute/writeback controller wrapped around an external
// combinational ALU: IDLE -> EXEC -> WB, one op at a time.
module alu_exec_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int SEL_W  = ALU_SEL_W,
  parameter int FLAG_W = ALU_FLAG_W,
  parameter int ADDR_W = ALU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [7:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] alu_operand1,
  output logic [DATA_W-1:0] alu_operand2,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic [FLAG_W-1:0] flags_q,
  output logic              done,
  output logic              illegal,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e            state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d;
  logic [ADDR_W-1:0] rs2_q, rs2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [FLAG_W-1:0] hflg_q, hflg_d;
  logic [FLAG_W-1:0] flags_d;

  logic [DATA_W-1:0] rs1_data, rs2_data;
  logic              we;
  logic [DATA_W-1:0] wdata;

  logic cls_alu, cls_ldi, cls_nop, cls_bad;

  always_comb begin
    cls_alu = is_alu_op(op_q);
    cls_ldi = (op_q == OP_LDI);
    cls_nop = (op_q == OP_NOP);
    cls_bad = !cls_alu && !cls_ldi && !cls_nop;
  end

  regfile_8x8 #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1_q),
    .rs2_addr (rs2_q),
    .dbg_addr (dbg_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dbg_data (dbg_data),
    .we       (we),
    .waddr    (rd_q),
    .wdata    (wdata)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rd_d         = rd_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    imm_d        = imm_q;
    res_d        = res_q;
    hflg_d       = hflg_q;
    flags_d      = flags_q;
    instr_ready  = 1'b0;
    alu_operand1 = '0;
    alu_operand2 = '0;
    alu_sel      = '0;
    done         = 1'b0;
    illegal      = 1'b0;
    we           = 1'b0;
    wdata        = '0;
    unique case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          op_d    = instr_op;
          rd_d    = instr_rd;
          rs1_d   = instr_rs1;
          rs2_d   = instr_rs2;
          imm_d   = instr_imm;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cls_alu) begin
          alu_operand1 = rs1_data;
          alu_operand2 = rs2_data;
          alu_sel      = SEL_W'(op_q);
        end
        res_d   = alu_result;
        hflg_d  = alu_flags;
        state_d = ST_WB;
      end
      ST_WB: begin
        done    = 1'b1;
        illegal = cls_bad;
        if (cls_alu) begin
          we      = 1'b1;
          wdata   = res_q;
          flags_d = hflg_q;
        end else if (cls_ldi) begin
          we    = 1'b1;
          wdata = imm_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      res_q   <= '0;
      hflg_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      res_q   <= res_d;
      hflg_q  <= hflg_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench: small ALU model, vector table, and
// handshake/throughput/reset-abort sequences.
module tb_alu_exec_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [7:0] instr_op = '0;
  logic [2:0] instr_rd = '0;
  logic [2:0] instr_rs1 = '0;
  logic [2:0] instr_rs2 = '0;
  logic [7:0] instr_imm = '0;
  logic [7:0] alu_operand1, alu_operand2;
  logic [7:0] alu_sel;
  logic [7:0] alu_result;
  logic [6:0] alu_flags;
  logic [6:0] flags_q;
  logic       done, illegal;
  logic [2:0] dbg_addr = '0;
  logic [7:0] dbg_data;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_exec_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_op     (instr_op),
    .instr_rd     (instr_rd),
    .instr_rs1    (instr_rs1),
    .instr_rs2    (instr_rs2),
    .instr_imm    (instr_imm),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_sel      (alu_sel),
    .alu_result   (alu_result),
    .alu_flags    (alu_flags),
    .flags_q      (flags_q),
    .done         (done),
    .illegal      (illegal),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  // Stand-in ALU: flags[0]=zero, flags[1]=carry/borrow.
  always_comb begin
    logic [8:0] w;
    w = '0;
    case (alu_sel)
      8'h01: w = {1'b0, alu_operand1} + {1'b0, alu_operand2};
      8'h02: w = {alu_operand1 < alu_operand2,
                  alu_operand1 - alu_operand2};
      8'h0A: w = {1'b0, alu_operand1 & alu_operand2};
      8'h0F: w = {1'b0, alu_operand1 | alu_operand2};
      8'h11: w = {1'b0, alu_operand1 ^ alu_operand2};
      default: w = '0;
    endcase
    alu_result = w[7:0];
    alu_flags  = {5'b0, w[8], (w[7:0] == 8'h00)};
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] op;
    logic [2:0] rd, rs1, rs2;
    logic [7:0] imm;
    logic [7:0] sel, op1, op2;
    logic       ill;
    logic [2:0] caddr;
    logic [7:0] cdata;
    logic [6:0] flags;
  } vec_t;

  vec_t vecs[12];

  task automatic wait_ready(input string name);
    int n = 0;
    while (!instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) chk({name, "_ready_timeout"}, 0, 1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string nm;
    nm = $sformatf("v%0d", idx);
    @(negedge clk);
    wait_ready(nm);
    instr_valid = 1'b1;
    instr_op    = v.op;
    instr_rd    = v.rd;
    instr_rs1   = v.rs1;
    instr_rs2   = v.rs2;
    instr_imm   = v.imm;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    chk({nm, "_exec_sel"}, alu_sel, v.sel);
    chk({nm, "_exec_op1"}, alu_operand1, v.op1);
    chk({nm, "_exec_op2"}, alu_operand2, v.op2);
    chk({nm, "_exec_nodone"}, done, 0);
    @(posedge clk);
    #1;
    chk({nm, "_wb_done"}, done, 1);
    chk({nm, "_wb_illegal"}, illegal, v.ill);
    @(posedge clk);
    #1;
    dbg_addr = v.caddr;
    #1;
    chk({nm, "_dbg"}, dbg_data, v.cdata);
    chk({nm, "_flags"}, flags_q, v.flags);
  endtask

  initial begin
    int acc, low, dn, dn_bad;
    //         op     rd    rs1   rs2   imm    sel    op1    op2  ill ca    cd     flg
    vecs[0]  = '{8'h80, 3'd1, 3'd0, 3'd0, 8'd10, 8'h00, 8'd0, 8'd0, 0, 3'd1, 8'd10, 7'd0};
    vecs[1]  = '{8'h80, 3'd2, 3'd0, 3'd0, 8'd15, 8'h00, 8'd0, 8'd0, 0, 3'd2, 8'd15, 7'd0};
    vecs[2]  = '{8'h01, 3'd3, 3'd1, 3'd2, 8'd0, 8'h01, 8'd10, 8'd15, 0, 3'd3, 8'd25, 7'd0};
    vecs[3]  = '{8'h80, 3'd1, 3'd0, 3'd0, 8'd255, 8'h00, 8'd0, 8'd0, 0, 3'd1, 8'd255, 7'd0};
    vecs[4]  = '{8'h80, 3'd2, 3'd0, 3'd0, 8'd1, 8'h00, 8'd0, 8'd0, 0, 3'd2, 8'd1, 7'd0};
    vecs[5]  = '{8'h01, 3'd1, 3'd1, 3'd2, 8'd0, 8'h01, 8'd255, 8'd1, 0, 3'd1, 8'd0, 7'd3};
    vecs[6]  = '{8'h0C, 3'd3, 3'd3, 3'd3, 8'd77, 8'h00, 8'd0, 8'd0, 1, 3'd3, 8'd25, 7'd3};
    vecs[7]  = '{8'h02, 3'd4, 3'd3, 3'd2, 8'd0, 8'h02, 8'd25, 8'd1, 0, 3'd4, 8'd24, 7'd0};
    vecs[8]  = '{8'h11, 3'd5, 3'd3, 3'd4, 8'd0, 8'h11, 8'd25, 8'd24, 0, 3'd5, 8'd1, 7'd0};
    vecs[9]  = '{8'h00, 3'd5, 3'd0, 3'd0, 8'd99, 8'h00, 8'd0, 8'd0, 0, 3'd5, 8'd1, 7'd0};
    vecs[10] = '{8'h81, 3'd6, 3'd1, 3'd2, 8'd42, 8'h00, 8'd0, 8'd0, 1, 3'd6, 8'd0, 7'd0};
    vecs[11] = '{8'h0A, 3'd6, 3'd3, 3'd3, 8'd0, 8'h0A, 8'd25, 8'd25, 0, 3'd6, 8'd25, 7'd0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      dbg_addr = 3'(a);
      #1;
      chk($sformatf("rst_dbg_r%0d", a), dbg_data, 0);
    end
    chk("rst_flags", flags_q, 0);
    chk("rst_ready", instr_ready, 1);
    chk("rst_sel", alu_sel, 0);
    chk("rst_done", done, 0);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Valid held high: one accept per three cycles.
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = 8'h00;
    acc = 0;
    low = 0;
    dn  = 0;
    for (int i = 0; i < 9; i++) begin
      if (instr_ready) acc++;
      else low++;
      if (done) dn++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("tput_accepts", acc, 3);
    chk("tput_busy", low, 6);
    chk("tput_done", dn, 3);

    // Reset during EXEC of ADD r4 aborts the op.
    wait_ready("abort");
    instr_valid = 1'b1;
    instr_op    = 8'h01;
    instr_rd    = 3'd4;
    instr_rs1   = 3'd3;
    instr_rs2   = 3'd2;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    chk("abort_exec_sel", alu_sel, 1);
    rst = 1'b1;
    #1;
    chk("abort_done", done, 0);
    chk("abort_ready", instr_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    dn_bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) dn_bad++;
    end
    chk("abort_no_done", dn_bad, 0);
    chk("abort_ready_post", instr_ready, 1);
    dbg_addr = 3'd4;
    #1;
    chk("abort_r4", dbg_data, 0);
    dbg_addr = 3'd3;
    #1;
    chk("abort_r3_cleared", dbg_data, 0);
    chk("abort_flags", flags_q, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
